// File: rtl/mac8_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mac8_seq_ctrl
//
// Sequencer for the shared 16-bit adder of the MAC8 datapath. One start pulse
// runs an unsigned OP_W x OP_W multiply as OP_W shift-add cycles through the
// external adder. A single accumulate cycle then follows, also through the
// adder. The block keeps the 16-bit accumulator and a sticky overflow flag.
//
// Build option:
//   MAC8_SATURATE_EN  defined   -> an accumulate carry saturates acc to all-ones
//                     undefined -> an accumulate carry wraps acc mod 2^16
//   In both builds an accumulate carry sets ovf.
//
// Parameters:
//   OP_W      operand width (only 8 is supported; 2*OP_W must equal adder width)
//   ACC_INIT  value loaded into acc on rst and on acc_clr
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   start    in   begin a MAC with op_a*op_b; sampled only in IDLE
//   acc_clr  in   load ACC_INIT into acc and clear ovf; sampled in IDLE/DONE
//   op_a     in   multiplicand, latched when start is accepted
//   op_b     in   multiplier, latched when start is accepted
//   busy     out  high while multiplying or accumulating
//   done     out  one-cycle pulse; acc holds the new result
//   acc      out  accumulator
//   ovf      out  sticky accumulate carry-out flag
//   add_a    out  adder operand A
//   add_b    out  adder operand B
//   add_cin  out  adder carry-in (constant 0)
//   add_sum  in   adder result, combinational from add_a/add_b/add_cin
//
// Handshake: start and acc_clr are level-sampled request strobes. They have no
// ready return; a strobe that arrives in a state that does not sample it is
// dropped, not queued.
// -----------------------------------------------------------------------------
module mac8_seq_ctrl #(
    parameter int                OP_W     = 8,
    parameter logic [2*OP_W-1:0] ACC_INIT = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                acc_clr,
    input  logic [OP_W-1:0]     op_a,
    input  logic [OP_W-1:0]     op_b,
    output logic                busy,
    output logic                done,
    output logic [2*OP_W-1:0]   acc,
    output logic                ovf,
    output logic [2*OP_W-1:0]   add_a,
    output logic [2*OP_W-1:0]   add_b,
    output logic                add_cin,
    input  logic [2*OP_W-1:0]   add_sum
);

    localparam int W     = 2 * OP_W;
    localparam int CNT_W = $clog2(OP_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_ACC  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state, state_next;
    logic [W-1:0]       mcand;
    logic [OP_W-1:0]    mplr;
    logic [W-1:0]       prod;
    logic [CNT_W-1:0]   cnt;
    logic               carry;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next state and adder operand steering
    always_comb begin
        state_next = state;
        add_a      = '0;
        add_b      = '0;
        add_cin    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_MUL;
            end
            S_MUL: begin
                busy  = 1'b1;
                add_a = prod;
                add_b = mplr[0] ? mcand : '0;
                if (cnt == CNT_W'(OP_W - 1)) state_next = S_ACC;
            end
            S_ACC: begin
                busy       = 1'b1;
                add_a      = acc;
                add_b      = prod;
                state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The carry-in is always 0, so a carry out of the MSB shows up as a
    // sum smaller than either operand.
    assign carry = (add_sum < acc);

    // Datapath and accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= ACC_INIT;
            ovf   <= 1'b0;
            mcand <= '0;
            mplr  <= '0;
            prod  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // The clear lands on the same edge as the operand latch,
                    // so start+acc_clr accumulates onto a fresh ACC_INIT.
                    if (acc_clr) begin
                        acc <= ACC_INIT;
                        ovf <= 1'b0;
                    end
                    if (start) begin
                        mcand <= {{OP_W{1'b0}}, op_a};
                        mplr  <= op_b;
                        prod  <= '0;
                        cnt   <= '0;
                    end
                end
                S_MUL: begin
                    prod  <= add_sum;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt + 1'b1;
                end
                S_ACC: begin
`ifdef MAC8_SATURATE_EN
                    if (carry) begin
                        acc <= '1;
                        ovf <= 1'b1;
                    end else begin
                        acc <= add_sum;
                    end
`else
                    acc <= add_sum;
                    if (carry) ovf <= 1'b1;
`endif
                end
                S_DONE: begin
                    if (acc_clr) begin
                        acc <= ACC_INIT;
                        ovf <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac8_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mac8_seq_ctrl
//
// Bench for mac8_seq_ctrl. It supplies the external adder as a plain
// continuous add. The reference model predicts each MAC result from integer
// arithmetic (acc + a*b, then wrap or saturate). It predicts each shift-add
// step as a times the low bits of b. Inputs change and outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_mac8_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        acc_clr;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        busy;
    logic        done;
    logic [15:0] acc;
    logic        ovf;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_cin;
    logic [15:0] add_sum;

    localparam logic [15:0] ACC0 = 16'h0000;

    int vectors    = 0;
    int miscompares = 0;

    // scoreboard: {ovf, acc} expected at each done pulse
    logic [16:0] exp_q[$];
    logic [15:0] m_acc;
    logic        m_ovf;

    mac8_seq_ctrl #(.OP_W(8), .ACC_INIT(ACC0)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .acc_clr (acc_clr),
        .op_a    (op_a),
        .op_b    (op_b),
        .busy    (busy),
        .done    (done),
        .acc     (acc),
        .ovf     (ovf),
        .add_a   (add_a),
        .add_b   (add_b),
        .add_cin (add_cin),
        .add_sum (add_sum)
    );

    // external adder
    assign add_sum = add_a + add_b + {15'b0, add_cin};

    // clock / reset
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // model: result of one MAC
    task automatic model_mac(input logic [7:0] a, input logic [7:0] b);
        int sum;
        sum = int'(m_acc) + int'(a) * int'(b);
`ifdef MAC8_SATURATE_EN
        if (sum > 65535) begin
            m_acc = 16'hFFFF;
            m_ovf = 1'b1;
        end else begin
            m_acc = 16'(sum);
        end
`else
        m_acc = 16'(sum);
        if (sum > 65535) m_ovf = 1'b1;
`endif
    endtask

    // driver: one MAC with optional disturbances
    //   stray     : pulse start during MUL cycle 3 (should be ignored)
    //   clr_mid   : pulse acc_clr during MUL (should be ignored)
    //   clr_done  : assert acc_clr while done is high (should clear)
    //   rst_at    : nonzero -> assert rst in MUL cycle rst_at-1
    task automatic run_mac(input logic [7:0] a, input logic [7:0] b, input bit clr,
                           input bit stray, input bit clr_mid, input bit clr_done,
                           input int rst_at);
        logic [16:0] e;
        bit          seen;
        int          busy_n;
        int          dones;
        int          part;
        @(negedge clk);
        check_val("idle_add_a", add_a, 0);
        check_val("idle_add_b", add_b, 0);
        check_val("idle_busy", busy, 0);
        start   = 1'b1;
        acc_clr = clr;
        op_a    = a;
        op_b    = b;
        if (clr) begin
            m_acc = ACC0;
            m_ovf = 1'b0;
        end
        model_mac(a, b);
        exp_q.push_back({m_ovf, m_acc});
        seen   = 0;
        busy_n = 0;
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(negedge clk);
            start   = 1'b0;
            acc_clr = 1'b0;
            rst     = 1'b0;
            op_a    = 8'($urandom);
            op_b    = 8'($urandom);
            if (rst_at != 0 && n == rst_at + 1) begin
                check_val("rst_busy", busy, 0);
                check_val("rst_done", done, 0);
                check_val("rst_acc", acc, ACC0);
                check_val("rst_ovf", ovf, 0);
                check_val("rst_add_a", add_a, 0);
                check_val("rst_add_b", add_b, 0);
                exp_q.delete();
                m_acc = ACC0;
                m_ovf = 1'b0;
                dones = 0;
                for (int i = 0; i < 12; i++) begin
                    @(negedge clk);
                    if (done) dones++;
                end
                check_val("rst_no_done", dones, 0);
                return;
            end
            if (busy) busy_n++;
            if (n <= 8) begin
                part = int'(a) * (int'(b) % (1 << n));
                check_val("mul_busy", busy, 1);
                check_val("mul_partial", add_sum, part);
                check_val("mul_cin", add_cin, 0);
            end
            if (stray && n == 4)    start   = 1'b1;
            if (clr_mid && n == 6)  acc_clr = 1'b1;
            if (rst_at == n)        rst     = 1'b1;
            if (done) begin
                seen = 1;
                check_val("done_latency", n, 10);
                check_val("busy_cycles", busy_n, 9);
                if (exp_q.size() == 0) begin
                    check_val("sb_empty", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("acc", acc, e[15:0]);
                    check_val("ovf", ovf, e[16]);
                end
                if (clr_done) begin
                    acc_clr = 1'b1;
                    m_acc   = ACC0;
                    m_ovf   = 1'b0;
                end
            end
        end
        if (!seen) check_val("done_timeout", 0, 1);
        @(negedge clk);
        acc_clr = 1'b0;
        check_val("post_done", done, 0);
        check_val("post_busy", busy, 0);
        if (clr_done) begin
            check_val("done_clr_acc", acc, ACC0);
            check_val("done_clr_ovf", ovf, 0);
        end
        // a stray start must not have launched a second MAC
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        check_val("single_done", dones, 0);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        acc_clr = 1'b0;
        op_a    = '0;
        op_b    = '0;
        m_acc   = ACC0;
        m_ovf   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("reset_acc", acc, ACC0);
        check_val("reset_ovf", ovf, 0);
        check_val("reset_busy", busy, 0);
        check_val("reset_done", done, 0);
        check_val("reset_add_a", add_a, 0);
        check_val("reset_add_b", add_b, 0);
        check_val("reset_cin", add_cin, 0);
        rst = 1'b0;

        run_mac(8'h0C, 8'h0A, 0, 0, 0, 0, 0);   // 0x0078
        run_mac(8'hFF, 8'hFF, 0, 0, 0, 0, 0);   // 0xFE79
        run_mac(8'hFF, 8'h03, 0, 0, 0, 0, 0);   // carry: wrap or saturate
        run_mac(8'($urandom), 8'($urandom), 0, 1, 0, 0, 0);
        run_mac(8'h02, 8'h03, 1, 0, 0, 0, 0);   // start+clr -> 0x0006
        run_mac(8'h00, 8'hFF, 0, 0, 1, 0, 0);   // zero operand, clr in MUL ignored

        for (int k = 0; k < 20; k++) begin
            run_mac(8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 4) == 0), 0);
        end

        run_mac(8'($urandom), 8'($urandom), 0, 0, 0, 0, 5);  // rst in MUL cycle 4
        run_mac(8'h11, 8'h22, 0, 0, 0, 0, 0);
        run_mac(8'($urandom), 8'($urandom), 0, 0, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
